// File: rtl/instr_reg_sequencer_if.sv
// Bus bundle for the instruction register sequencer: producer handshake,
// register write port, register read port, consumer handshake, flush and
// occupancy. The sequencer uses the master view; the surroundings use slave.
interface instr_reg_sequencer_if #(
    parameter int PTR_W = 5,
    parameter int OP_W  = 32,
    parameter int RES_W = 64
);
    // Flush and occupancy
    logic                    clear;
    logic [PTR_W:0]          count;

    // Producer handshake
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              in_opcode;
    logic signed [OP_W-1:0]  in_op_a;
    logic signed [OP_W-1:0]  in_op_b;

    // Register write port
    logic                    load_en;
    logic [PTR_W-1:0]        write_pointer;
    logic [3:0]              opcode;
    logic signed [OP_W-1:0]  operand_a;
    logic signed [OP_W-1:0]  operand_b;

    // Register read port (combinational read)
    logic [PTR_W-1:0]        read_pointer;
    logic [3:0]              iw_opcode;
    logic signed [OP_W-1:0]  iw_op_a;
    logic signed [OP_W-1:0]  iw_op_b;

    // Consumer handshake
    logic                    out_valid;
    logic                    out_ready;
    logic signed [RES_W-1:0] out_res;
    logic                    out_err;

    modport master (
        input  clear, in_valid, in_opcode, in_op_a, in_op_b,
               iw_opcode, iw_op_a, iw_op_b, out_ready,
        output count, in_ready, load_en, write_pointer, opcode,
               operand_a, operand_b, read_pointer,
               out_valid, out_res, out_err
    );

    modport slave (
        output clear, in_valid, in_opcode, in_op_a, in_op_b,
               iw_opcode, iw_op_a, iw_op_b, out_ready,
        input  count, in_ready, load_en, write_pointer, opcode,
               operand_a, operand_b, read_pointer,
               out_valid, out_res, out_err
    );
endinterface

// File: rtl/instr_reg_sequencer.sv
// In-order scheduler for an external DEPTH-entry instruction register used as
// a circular FIFO. Accepted instructions are written through the register
// write port; the oldest entry is fetched, executed in a small signed ALU and
// presented to the consumer, one result every four cycles at best.
module instr_reg_sequencer #(
    parameter int DEPTH = 32,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int OP_W  = 32,
    parameter int RES_W = 2 * OP_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instr_reg_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          count_q, count_d;
    logic [3:0]              opc_q, opc_d;
    logic signed [OP_W-1:0]  a_q, a_d;
    logic signed [OP_W-1:0]  b_q, b_d;
    logic signed [RES_W-1:0] res_q, res_d;
    logic                    err_q, err_d;

    logic                    in_ready;
    logic                    accept;
    logic                    retire;
    logic signed [RES_W-1:0] a_ext, b_ext;
    logic signed [RES_W-1:0] alu_res;
    logic                    alu_err;

    // Write-side handshake: decided purely from registered occupancy so a
    // same-cycle retire never opens a slot early; held off while in reset.
    always_comb begin
        in_ready = reset_n && (count_q < FULL_COUNT) && !bus.clear;
        accept   = bus.in_valid && in_ready;
        retire   = (state_q == S_HOLD) && bus.out_ready && !bus.clear;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a flush overrides everything and returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (count_q != '0) state_d = S_FETCH;
                S_FETCH: state_d = S_EXEC;
                S_EXEC:  state_d = S_HOLD;
                S_HOLD:  if (bus.out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM and write-port outputs; out_valid is a pure decode of HOLD so it
    // can only fall on a handshake, a flush or a reset.
    always_comb begin
        bus.in_ready      = in_ready;
        bus.load_en       = accept;
        bus.write_pointer = wr_ptr_q;
        bus.opcode        = bus.in_opcode;
        bus.operand_a     = bus.in_op_a;
        bus.operand_b     = bus.in_op_b;
        bus.read_pointer  = rd_ptr_q;
        bus.count         = count_q;
        bus.out_valid     = (state_q == S_HOLD);
        bus.out_res       = res_q;
        bus.out_err       = err_q;
    end

    // Signed ALU on the captured instruction; operands are sign-extended so
    // the product is exact and MIN/-1 cannot overflow.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        a_ext   = {{(RES_W - OP_W){a_q[OP_W-1]}}, a_q};
        b_ext   = {{(RES_W - OP_W){b_q[OP_W-1]}}, b_q};
        alu_res = '0;
        alu_err = 1'b0;
        unique case (opc_q)
            OP_ZERO:  alu_res = '0;
            OP_PASSA: alu_res = a_ext;
            OP_PASSB: alu_res = b_ext;
            OP_ADD:   alu_res = a_ext + b_ext;
            OP_SUB:   alu_res = a_ext - b_ext;
            OP_MULT:  alu_res = a_ext * b_ext;
            OP_DIV: begin
                if (b_q == '0) alu_err = 1'b1;
                else           alu_res = a_ext / b_ext;
            end
            OP_MOD: begin
                if (b_q == '0) alu_err = 1'b1;
                else           alu_res = a_ext % b_ext;
            end
            default:  alu_err = 1'b1;
        endcase
    end

    // Datapath next state: pointers, occupancy, instruction capture, result.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        opc_d    = opc_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        err_d    = err_q;
        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            res_d    = '0;
            err_d    = 1'b0;
        end else begin
            if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (retire) rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({accept, retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (state_q == S_FETCH) begin
                opc_d = bus.iw_opcode;
                a_d   = bus.iw_op_a;
                b_d   = bus.iw_op_b;
            end
            if (state_q == S_EXEC) begin
                res_d = alu_res;
                err_d = alu_err;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            opc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            opc_q    <= opc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_reg_sequencer.sv
// Directed bench for instr_reg_sequencer: an external 32-entry register array
// is written through the DUT write port and read combinationally at
// read_pointer; results are compared against hand-computed values.
module tb_instr_reg_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    instr_reg_sequencer_if #(.PTR_W(5), .OP_W(32), .RES_W(64)) bus ();

    instr_reg_sequencer #(.DEPTH(32), .PTR_W(5), .OP_W(32), .RES_W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // External instruction register.
    logic [3:0]  rf_opc [32];
    logic [31:0] rf_a   [32];
    logic [31:0] rf_b   [32];

    always @(posedge clk) begin
        if (bus.load_en) begin
            rf_opc[bus.write_pointer] <= bus.opcode;
            rf_a[bus.write_pointer]   <= bus.operand_a;
            rf_b[bus.write_pointer]   <= bus.operand_b;
        end
    end

    assign bus.iw_opcode = rf_opc[bus.read_pointer];
    assign bus.iw_op_a   = rf_a[bus.read_pointer];
    assign bus.iw_op_b   = rf_b[bus.read_pointer];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction; wp returns the write pointer of the accepting
    // cycle, or -1 if in_ready never came.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int wp);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_op_a   = a;
        bus.in_op_b   = b;
        #1;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        wp = bus.in_ready ? int'(bus.write_pointer) : -1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Wait for a result (bounded) and complete its handshake.
    task automatic take(output logic [63:0] res, output logic err, output bit ok);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        ok  = bus.out_valid;
        res = bus.out_res;
        err = bus.out_err;
        if (ok) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_op_a   = '0;
        bus.in_op_b   = '0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        #12;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 6'd0 || bus.load_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b count=%0d load_en=%b, required 0/0/0",
                     bus.out_valid, bus.count, bus.load_en);
        end
        checks++;
        if (bus.out_res !== 64'd0 || bus.out_err !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: out_res=%0d out_err=%b in_ready=%b, required 0/0/0",
                     bus.out_res, bus.out_err, bus.in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.write_pointer !== 5'd0 || bus.read_pointer !== 5'd0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b wp=%0d rp=%0d, required 1/0/0",
                     bus.in_ready, bus.write_pointer, bus.read_pointer);
        end
        tick();
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 4'd3;
        bus.in_op_a   = 32'd5;
        bus.in_op_b   = 32'd7;
        #1;
        checks++;
        if (bus.load_en !== 1'b1 || bus.write_pointer !== 5'd0) begin
            errors++;
            $display("FAIL single_load: load_en=%b wp=%0d, required 1/0",
                     bus.load_en, bus.write_pointer);
        end
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.load_en !== 1'b0 || bus.count !== 6'd1) begin
            errors++;
            $display("FAIL single_after: load_en=%b count=%0d, required 0/1",
                     bus.load_en, bus.count);
        end
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: out_valid=%b at accept+3, required 0", bus.out_valid);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_res !== 64'sd12 || bus.out_err !== 1'b0) begin
            errors++;
            $display("FAIL single_result: valid=%b res=%0d err=%b, required 1/12/0",
                     bus.out_valid, $signed(bus.out_res), bus.out_err);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 6'd0) begin
            errors++;
            $display("FAIL single_retire: valid=%b count=%0d, required 0/0",
                     bus.out_valid, bus.count);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops  [6] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd2, 4'd5};
        logic [31:0] as   [6] = '{32'd3, -32'sd4, -32'sd7, -32'sd7, 32'd0, 32'h8000_0000};
        logic [31:0] bs   [6] = '{32'd10, 32'd6, 32'd2, 32'd2, 32'd9, 32'h8000_0000};
        longint      exps [6] = '{-64'sd7, -64'sd24, -64'sd3, -64'sd1, 64'sd9,
                                  64'sh4000_0000_0000_0000};
        int wp;
        logic [63:0] res;
        logic err;
        bit ok;
        for (int i = 0; i < 6; i++) send(ops[i], as[i], bs[i], wp);
        checks++;
        if (bus.count !== 6'd6) begin
            errors++;
            $display("FAIL b2b_count: count=%0d, required 6", bus.count);
        end
        for (int i = 0; i < 6; i++) begin
            take(res, err, ok);
            checks++;
            if (!ok || res !== 64'(exps[i]) || err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_result[%0d]: valid=%b res=%0d err=%b, required 1/%0d/0",
                         i, ok, $signed(res), err, exps[i]);
            end
        end
    endtask

    task automatic test_errors();
        int wp;
        logic [63:0] res;
        logic err;
        bit ok;
        send(4'd6, 32'd8, 32'd0, wp);
        send(4'd12, 32'd1, 32'd1, wp);
        for (int i = 0; i < 2; i++) begin
            take(res, err, ok);
            checks++;
            if (!ok || res !== 64'd0 || err !== 1'b1) begin
                errors++;
                $display("FAIL err_result[%0d]: valid=%b res=%0d err=%b, required 1/0/1",
                         i, ok, $signed(res), err);
            end
        end
    endtask

    task automatic test_full_wrap();
        int wp;
        logic [63:0] res;
        logic err;
        bit ok;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send(4'd1, 32'(i), 32'd0, wp);
            checks++;
            if (wp != i) begin
                errors++;
                $display("FAIL full_wp[%0d]: write_pointer=%0d, required %0d", i, wp, i);
            end
        end
        bus.in_valid  = 1'b1;
        bus.in_opcode = 4'd1;
        bus.in_op_a   = 32'd100;
        bus.in_op_b   = 32'd0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.count !== 6'd32 || bus.load_en !== 1'b0) begin
            errors++;
            $display("FAIL full_block: in_ready=%b count=%0d load_en=%b, required 0/32/0",
                     bus.in_ready, bus.count, bus.load_en);
        end
        tick();
        checks++;
        if (bus.load_en !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_res !== 64'd0) begin
            errors++;
            $display("FAIL full_head: load_en=%b valid=%b res=%0d, required 0/1/0",
                     bus.load_en, bus.out_valid, $signed(bus.out_res));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.load_en !== 1'b1 || bus.write_pointer !== 5'd0 || bus.count !== 6'd31) begin
            errors++;
            $display("FAIL full_wrap: load_en=%b wp=%0d count=%0d, required 1/0/31",
                     bus.load_en, bus.write_pointer, bus.count);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.count !== 6'd32) begin
            errors++;
            $display("FAIL full_refill: count=%0d, required 32", bus.count);
        end
        for (int i = 1; i <= 32; i++) begin
            take(res, err, ok);
            checks++;
            if (!ok || res !== ((i == 32) ? 64'd100 : 64'(i)) || err !== 1'b0) begin
                errors++;
                $display("FAIL full_order[%0d]: valid=%b res=%0d err=%b, required 1/%0d/0",
                         i, ok, $signed(res), err, (i == 32) ? 100 : i);
            end
        end
    endtask

    task automatic test_clear();
        int wp;
        int n = 0;
        logic [63:0] res;
        logic err;
        bit ok;
        send(4'd1, 32'd11, 32'd0, wp);
        send(4'd1, 32'd22, 32'd0, wp);
        send(4'd1, 32'd33, 32'd0, wp);
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.count !== 6'd3) begin
            errors++;
            $display("FAIL clear_setup: valid=%b count=%0d, required 1/3", bus.out_valid, bus.count);
        end
        bus.clear     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 4'd1;
        bus.in_op_a   = 32'd99;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.load_en !== 1'b0) begin
            errors++;
            $display("FAIL clear_block: in_ready=%b load_en=%b, required 0/0",
                     bus.in_ready, bus.load_en);
        end
        tick();
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.count !== 6'd0 || bus.out_valid !== 1'b0 || bus.read_pointer !== 5'd0) begin
            errors++;
            $display("FAIL clear_state: count=%0d valid=%b rp=%0d, required 0/0/0",
                     bus.count, bus.out_valid, bus.read_pointer);
        end
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle: out_valid=%b with empty queue, required 0", bus.out_valid);
        end
        send(4'd1, 32'd7, 32'd0, wp);
        checks++;
        if (wp != 0) begin
            errors++;
            $display("FAIL clear_wp: write_pointer=%0d, required 0", wp);
        end
        take(res, err, ok);
        checks++;
        if (!ok || res !== 64'd7 || err !== 1'b0) begin
            errors++;
            $display("FAIL clear_result: valid=%b res=%0d err=%b, required 1/7/0",
                     ok, $signed(res), err);
        end
    endtask

    task automatic test_async_reset();
        int wp;
        logic [63:0] res;
        logic err;
        bit ok;
        send(4'd3, 32'd1, 32'd2, wp);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 6'd0 || bus.read_pointer !== 5'd0) begin
            errors++;
            $display("FAIL areset_outputs: valid=%b count=%0d rp=%0d, required 0/0/0",
                     bus.out_valid, bus.count, bus.read_pointer);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        send(4'd1, 32'd42, 32'd0, wp);
        checks++;
        if (wp != 0) begin
            errors++;
            $display("FAIL areset_wp: write_pointer=%0d, required 0", wp);
        end
        take(res, err, ok);
        checks++;
        if (!ok || res !== 64'd42 || err !== 1'b0) begin
            errors++;
            $display("FAIL areset_result: valid=%b res=%0d err=%b, required 1/42/0",
                     ok, $signed(res), err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_errors();
        test_full_wrap();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
                 errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/instr_reg_sequencer.md
Name: instr_reg_sequencer

Overview:
- In-order scheduler for the 32-entry instruction register.
- Accepts instructions from a producer over a valid/ready handshake and drives the register write port (load_en, write_pointer, opcode, operands).
- Fetches the oldest stored entry through read_pointer, executes it in a small integer ALU, and presents the result to a consumer over a second valid/ready handshake.
- Treats the register file as a circular FIFO with occupancy tracking.

Parameters:
- DEPTH, 32, number of register entries; must be a power of two.
- PTR_W, 5, pointer width; equals log2(DEPTH).
- OP_W, 32, signed operand width.
- RES_W, 64, signed result width; equals 2*OP_W.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of all queued and in-flight work.
- in_valid  in  1  producer has an instruction.
- in_ready  out  1  sequencer can accept an instruction.
- in_opcode  in  4  opcode.
- in_op_a  in  OP_W  operand A, signed.
- in_op_b  in  OP_W  operand B, signed.
- load_en  out  1  write strobe to the register.
- write_pointer  out  PTR_W  write address.
- opcode  out  4  write data: opcode.
- operand_a  out  OP_W  write data: operand A.
- operand_b  out  OP_W  write data: operand B.
- read_pointer  out  PTR_W  read address.
- iw_opcode  in  4  opcode of the entry at read_pointer.
- iw_op_a  in  OP_W  operand A of the entry at read_pointer.
- iw_op_b  in  OP_W  operand B of the entry at read_pointer.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_res  out  RES_W  signed result.
- out_err  out  1  divide or modulo by zero, or illegal opcode.
- count  out  PTR_W+1  occupancy, 0..DEPTH.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, FSM=IDLE.
  - out_valid=0, out_res=0, out_err=0.
  - load_en=0; in_ready becomes 1 once reset is released.
- Write side (combinational on registered state):
  - in_ready = (count<DEPTH) && !clear.
  - load_en = in_valid && in_ready.
  - write_pointer=wr_ptr; opcode/operand_a/operand_b pass through in_opcode/in_op_a/in_op_b.
  - On each accept, wr_ptr increments modulo DEPTH; 31 wraps to 0.
- Read pointer: read_pointer = rd_ptr at all times. The register read is combinational.
- FSM states:
  - IDLE: if count>0, go to FETCH. The count check uses the registered value, so a same-cycle write is not visible.
  - FETCH: capture iw_* into internal registers, go to EXEC.
  - EXEC: compute the result into out_res/out_err, go to HOLD.
  - HOLD: out_valid=1. When out_ready=1: rd_ptr increments modulo DEPTH, count decrements, go to IDLE. out_res and out_err hold stable until the handshake completes.
- Latency:
  - Instruction accepted into an empty queue in cycle N: out_valid asserts in cycle N+4.
  - Sustained throughput: one result per 4 cycles with out_ready held high.
- Count update:
  - +1 on accept, -1 on retire.
  - Simultaneous accept and retire: count unchanged, both pointers advance.
- ALU (operands sign-extended to RES_W):
  - 0 ZERO: 0.
  - 1 PASSA: a.
  - 2 PASSB: b.
  - 3 ADD: a+b.
  - 4 SUB: a-b.
  - 5 MULT: a*b, full 64-bit product.
  - 6 DIV: a/b, truncating toward zero.
  - 7 MOD: a%b, sign follows a.
  - b==0 with DIV or MOD: res=0, err=1.
  - Opcodes 8-15: res=0, err=1.
  - err=0 in all other cases.
- Full: when count==DEPTH, in_ready=0 and no writes occur. in_ready returns the cycle after a retire.
- Empty: FSM stays in IDLE and out_valid=0.
- Clear (clear=1 at a rising edge):
  - wr_ptr, rd_ptr and count go to 0; FSM goes to IDLE; out_valid=0.
  - An in-flight result is discarded, and a same-cycle retire is ignored.
  - in_ready=0 during clear, so no write occurs.
  - Register contents are not altered.
- Reset mid-operation: pending and in-flight entries are dropped with identical effect to clear. All outputs take their reset values immediately.
- out_valid must not drop without a handshake, except on clear or reset.

Test Plan:
- Reset, then write {ADD, 5, 7} with out_ready=1 -> load_en for 1 cycle at write_pointer 0; out_valid 4 cycles after the accept with out_res=12, out_err=0; count returns to 0.
- Write {SUB,3,10}, {MULT,-4,6}, {DIV,-7,2}, {MOD,-7,2}, {PASSB,0,9} back-to-back -> results in order: -7, -24, -3, -1, 9; all out_err=0.
- Write {DIV,8,0} then {opcode 12,1,1} -> out_res=0 with out_err=1 for both entries.
- Hold out_ready=0 and offer 33 instructions -> 32 accepted at pointers 0..31; in_ready=0 with count=32; release out_ready -> 33rd accepted at write_pointer 0 (wrap); read order is preserved.
- With 3 entries queued and FSM in HOLD, assert clear for 1 cycle together with in_valid=1 and out_ready=1 -> count=0, out_valid=0, no load_en that cycle; the next write lands at pointer 0.
- Deassert reset_n asynchronously mid-EXEC -> out_valid=0 and count=0 immediately; after release, {PASSA,42,0} returns 42 from pointer 0.
